// File: rtl/niosiisystem_nios2_debug_slave_cmd_queue.sv
// System-clock side of the Nios II JTAG debug slave. It synchronises the update-DR and
// update-IR toggles, queues the captured {ir, sr} words, and issues per-IR action pulses.
module niosiisystem_nios2_debug_slave_cmd_queue #(
    parameter int unsigned DATA_W      = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACT_BIT     = 35
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_W-1:0]              sr,
    input  logic [IR_W-1:0]                ir_in,
    input  logic                           udr_tgl,
    input  logic                           uir_tgl,
    input  logic                           cmd_ready,
    input  logic                           clr_overflow,
    output logic                           cmd_valid,
    output logic [DATA_W-1:0]              jdo,
    output logic [IR_W-1:0]                jdo_ir,
    output logic [(1 << IR_W)-1:0]         take_action,
    output logic [(1 << IR_W)-1:0]         take_no_action,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_level,
    output logic                           overflow,
    output logic                           uir_pulse
);

    localparam int unsigned NCH     = 1 << IR_W;
    localparam int unsigned ENT_W   = IR_W + DATA_W;
    localparam int unsigned LVL_W   = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

    // Elaboration-time guard against unsupported parameter combinations
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $error("DEPTH must be at least 2");
        end
        if (ACT_BIT >= DATA_W) begin : g_bad_act
            $error("ACT_BIT must be below DATA_W");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
    logic                   udr_prev_q, udr_prev_d;
    logic                   uir_prev_q, uir_prev_d;
    logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;

    logic [ENT_W-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;

    logic                   cmd_valid_q, cmd_valid_d;
    logic [DATA_W-1:0]      jdo_q, jdo_d;
    logic [IR_W-1:0]        jdo_ir_q, jdo_ir_d;
    logic [NCH-1:0]         act_q, act_d;
    logic [NCH-1:0]         noact_q, noact_d;
    logic                   ovf_q, ovf_d;
    logic                   uir_pulse_q, uir_pulse_d;

    logic                   armed;
    logic                   udr_evt;
    logic                   uir_evt;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic [ENT_W-1:0]       head;
    logic [IR_W-1:0]        head_ir;
    logic [DATA_W-1:0]      head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Event detection and FIFO control
    always_comb begin
        udr_sync_d  = {udr_sync_q[SYNC_STAGES-2:0], udr_tgl};
        uir_sync_d  = {uir_sync_q[SYNC_STAGES-2:0], uir_tgl};
        udr_prev_d  = udr_sync_q[SYNC_STAGES-1];
        uir_prev_d  = uir_sync_q[SYNC_STAGES-1];
        arm_cnt_d   = arm_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        jdo_d       = jdo_q;
        jdo_ir_d    = jdo_ir_q;
        act_d       = '0;
        noact_d     = '0;
        ovf_d       = ovf_q;

        armed     = (arm_cnt_q == ARM_W'(ARM_MAX));
        udr_evt   = armed && (udr_sync_q[SYNC_STAGES-1] ^ udr_prev_q);
        uir_evt   = armed && (uir_sync_q[SYNC_STAGES-1] ^ uir_prev_q);
        full      = (level_q == LVL_W'(DEPTH));
        pop       = cmd_valid_q && cmd_ready;
        push      = udr_evt && (!full || pop);
        drop      = udr_evt && full && !pop;
        head      = mem_q[rd_ptr_q];
        head_ir   = head[ENT_W-1:DATA_W];
        head_data = head[DATA_W-1:0];

        if (!armed) begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        if (pop) begin
            rd_ptr_d         = ptr_inc(rd_ptr_q);
            jdo_d            = head_data;
            jdo_ir_d         = head_ir;
            act_d[head_ir]   = head_data[ACT_BIT];
            noact_d[head_ir] = ~head_data[ACT_BIT];
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A drop on the same edge as a clear request leaves the flag set
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end

        cmd_valid_d = (level_d != '0);
        uir_pulse_d = uir_evt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_sync_q  <= '0;
            uir_sync_q  <= '0;
            udr_prev_q  <= 1'b0;
            uir_prev_q  <= 1'b0;
            arm_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cmd_valid_q <= 1'b0;
            jdo_q       <= '0;
            jdo_ir_q    <= '0;
            act_q       <= '0;
            noact_q     <= '0;
            ovf_q       <= 1'b0;
            uir_pulse_q <= 1'b0;
        end else begin
            udr_sync_q  <= udr_sync_d;
            uir_sync_q  <= uir_sync_d;
            udr_prev_q  <= udr_prev_d;
            uir_prev_q  <= uir_prev_d;
            arm_cnt_q   <= arm_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cmd_valid_q <= cmd_valid_d;
            jdo_q       <= jdo_d;
            jdo_ir_q    <= jdo_ir_d;
            act_q       <= act_d;
            noact_q     <= noact_d;
            ovf_q       <= ovf_d;
            uir_pulse_q <= uir_pulse_d;
        end
    end

    // Storage carries no reset; entries are only read while counted in level_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ir_in, sr};
        end
    end

    assign cmd_valid      = cmd_valid_q;
    assign jdo            = jdo_q;
    assign jdo_ir         = jdo_ir_q;
    assign take_action    = act_q;
    assign take_no_action = noact_q;
    assign fifo_level     = level_q;
    assign overflow       = ovf_q;
    assign uir_pulse      = uir_pulse_q;

endmodule
